// File: rtl/stage_ma.sv
// stage_ma: RV32I memory-access stage. Runs the data-memory req/ack transaction and registers write-back data.
// ALU ops and faults take 1 cycle. Loads and stores hold stall until mem_ack or timeout; stall is never raised otherwise.
module stage_ma #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] busc_in,
  input  logic [31:0] busb_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic [6:0]  op_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_we,
  output logic        mem_fault,
  output logic [31:0] fault_pc
);
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  // Snapshot of the in-flight access, so completion does not depend on upstream holding its outputs.
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d;
  logic        ld_q, ld_d;

  logic        is_load, is_store, f3_legal, misaligned, mem_op, alu_op, timeout, stall_c;
  logic [1:0]  lane;
  logic [31:0] st_wdata, rshift, ld_data;
  logic [3:0]  st_be;

  assign lane = busc_in[1:0];

  always_comb begin
    is_load    = (op_in == OP_LOAD);
    is_store   = (op_in == OP_STORE);
    f3_legal   = 1'b0;
    if (is_load)
      f3_legal = funct3_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store)
      f3_legal = funct3_in inside {3'b000, 3'b001, 3'b010};
    misaligned = ((funct3_in[1:0] == 2'b01) && lane[0]) ||
                 ((funct3_in[1:0] == 2'b10) && (lane != 2'b00));
    mem_op     = valid_in && (is_load || is_store);
    alu_op     = op_in inside {7'b0110011, 7'b0010011, 7'b0110111,
                               7'b0010111, 7'b1101111, 7'b1100111};
  end

  always_comb begin
    st_wdata = busb_in;
    st_be    = 4'hF;
    case (funct3_in[1:0])
      2'b00: begin
        st_wdata = {4{busb_in[7:0]}};
        st_be    = 4'b0001 << lane;
      end
      2'b01: begin
        st_wdata = {2{busb_in[15:0]}};
        st_be    = 4'b0011 << lane;
      end
      default: ;
    endcase
  end

  always_comb begin
    rshift = mem_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  ld_data = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  ld_data = {24'h0, rshift[7:0]};
      3'b101:  ld_data = {16'h0, rshift[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // An ack in the same cycle as the last allowed BUSY cycle wins over the timeout.
  assign timeout = TO_EN && !mem_ack && (cnt_q == TO_LAST);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    fault_d    = 1'b0;
    fault_pc_d = fault_pc_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    ld_d       = ld_q;
    stall_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && f3_legal && !misaligned) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {busc_in[31:2], 2'b00};
          wdata_d = is_store ? st_wdata : 32'h0;
          be_d    = is_store ? st_be : 4'hF;
          wb_we_d = 1'b0;
          lane_d  = lane;
          f3_d    = funct3_in;
          rd_d    = rd_in;
          pc_d    = pc_in;
          ld_d    = is_load;
          stall_c = 1'b1;
        end else if (mem_op) begin
          fault_d    = 1'b1;
          fault_pc_d = pc_in;
          wb_we_d    = 1'b0;
        end else if (valid_in) begin
          wb_data_d = busc_in;
          wb_rd_d   = rd_in;
          wb_we_d   = alu_op && (rd_in != 5'd0);
        end else begin
          wb_we_d = 1'b0;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wb_rd_d = rd_q;
          if (ld_q) begin
            wb_data_d = ld_data;
            wb_we_d   = (rd_q != 5'd0);
          end else begin
            wb_we_d = 1'b0;
          end
        end else if (timeout) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          wb_we_d    = 1'b0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
          stall_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
      lane_q     <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      pc_q       <= '0;
      ld_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      ld_q       <= ld_d;
    end
  end

  assign stall     = rst_n & stall_c;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign wb_data   = wb_data_q;
  assign wb_rd     = wb_rd_q;
  assign wb_we     = wb_we_q;
  assign mem_fault = fault_q;
  assign fault_pc  = fault_pc_q;
endmodule

// File: tb/tb_stage_ma.sv
// Directed bench for stage_ma: one task per scenario, expected values worked out by hand.
module tb_stage_ma;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] ADD    = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] busc_in, busb_in, pc_in, mem_rdata;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic [6:0]  op_in;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, wb_we, mem_fault;
  logic [31:0] mem_addr, mem_wdata, wb_data, fault_pc;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  stage_ma #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .busc_in(busc_in), .busb_in(busb_in),
    .pc_in(pc_in), .rd_in(rd_in), .funct3_in(funct3_in), .op_in(op_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we), .mem_fault(mem_fault), .fault_pc(fault_pc)
  );

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] c, input logic [31:0] b, input logic [4:0] rd,
                       input logic [31:0] pc);
    valid_in = v; op_in = op; funct3_in = f3; busc_in = c; busb_in = b; rd_in = rd; pc_in = pc;
  endtask

  task automatic idle();
    drive(1'b0, 7'd0, 3'd0, 32'h0, 32'h0, 5'd0, 32'h0);
    mem_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0;
    drive(1'b1, STORE, 3'b010, 32'h100, 32'h1234, 5'd0, 32'h8);
    next_cycle();
    total_cnt++; if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall); else pass_cnt++;
    total_cnt++; if ({mem_req, mem_we, mem_be} !== 6'b0) $display("FAIL rst_req_we_be got %b exp 0", {mem_req, mem_we, mem_be}); else pass_cnt++;
    total_cnt++; if ({mem_addr, mem_wdata} !== 64'h0) $display("FAIL rst_addr_wdata got %h exp 0", {mem_addr, mem_wdata}); else pass_cnt++;
    total_cnt++; if ({wb_data, wb_rd, wb_we, mem_fault, fault_pc} !== 71'h0) $display("FAIL rst_wb_fault got %h exp 0", {wb_data, wb_rd, wb_we, mem_fault, fault_pc}); else pass_cnt++;
    idle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_sw();
    int stall_hi = 0;
    drive(1'b1, STORE, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h10);
    #1; if (stall === 1'b1) stall_hi++;
    next_cycle();
    total_cnt++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL sw_req_we got %b exp 11", {mem_req, mem_we}); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h100) $display("FAIL sw_addr got %h exp 00000100", mem_addr); else pass_cnt++;
    total_cnt++; if (mem_be !== 4'hF) $display("FAIL sw_be got %h exp f", mem_be); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL sw_wdata got %h exp deadbeef", mem_wdata); else pass_cnt++;
    if (stall === 1'b1) stall_hi++;
    next_cycle();
    // Memory answers the request seen on the first BUSY cycle during the following cycle.
    mem_ack = 1'b1;
    #1; if (stall === 1'b1) stall_hi++;
    total_cnt++; if (stall_hi !== 2) $display("FAIL sw_stall_cycles got %0d exp 2", stall_hi); else pass_cnt++;
    next_cycle();
    idle();
    total_cnt++; if ({mem_req, wb_we} !== 2'b00) $display("FAIL sw_done got req/we %b exp 00", {mem_req, wb_we}); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_sb();
    drive(1'b1, STORE, 3'b000, 32'h103, 32'h000000A5, 5'd0, 32'h14);
    next_cycle();
    total_cnt++; if (mem_be !== 4'b1000) $display("FAIL sb_be got %b exp 1000", mem_be); else pass_cnt++;
    total_cnt++; if (mem_wdata !== 32'hA5A5A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", mem_wdata); else pass_cnt++;
    total_cnt++; if (mem_addr !== 32'h100) $display("FAIL sb_addr got %h exp 00000100", mem_addr); else pass_cnt++;
    mem_ack = 1'b1;
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_lb();
    drive(1'b1, LOAD, 3'b000, 32'h103, 32'h0, 5'd5, 32'h18);
    next_cycle();
    total_cnt++; if ({mem_req, mem_we, mem_be} !== 6'b10_1111) $display("FAIL lb_req_we_be got %b exp 101111", {mem_req, mem_we, mem_be}); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'h80123456;
    next_cycle();
    idle();
    total_cnt++; if (wb_data !== 32'hFFFFFF80) $display("FAIL lb_data got %h exp ffffff80", wb_data); else pass_cnt++;
    total_cnt++; if ({wb_we, wb_rd} !== {1'b1, 5'd5}) $display("FAIL lb_we_rd got %b/%0d exp 1/5", wb_we, wb_rd); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_lhu();
    for (int pass = 0; pass < 2; pass++) begin
      drive(1'b1, LOAD, 3'b101, 32'h102, 32'h0, (pass == 0) ? 5'd7 : 5'd0, 32'h1C);
      next_cycle();
      mem_ack = 1'b1; mem_rdata = 32'hBEEF1234;
      next_cycle();
      idle();
      total_cnt++; if (wb_data !== 32'h0000BEEF) $display("FAIL lhu_data_%0d got %h exp 0000beef", pass, wb_data); else pass_cnt++;
      total_cnt++; if (wb_we !== (pass == 0)) $display("FAIL lhu_we_%0d got %b exp %b", pass, wb_we, pass == 0); else pass_cnt++;
      next_cycle();
    end
  endtask

  task automatic test_fault();
    drive(1'b1, LOAD, 3'b010, 32'h102, 32'h0, 5'd2, 32'h40);
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL lw_mis_stall got %b exp 0", stall); else pass_cnt++;
    next_cycle();
    idle();
    total_cnt++; if (mem_req !== 1'b0) $display("FAIL lw_mis_req got %b exp 0", mem_req); else pass_cnt++;
    total_cnt++; if ({mem_fault, wb_we} !== 2'b10) $display("FAIL lw_mis_fault_we got %b exp 10", {mem_fault, wb_we}); else pass_cnt++;
    total_cnt++; if (fault_pc !== 32'h40) $display("FAIL lw_mis_pc got %h exp 00000040", fault_pc); else pass_cnt++;
    next_cycle();
    total_cnt++; if ({mem_fault, fault_pc} !== {1'b0, 32'h40}) $display("FAIL fault_pulse_hold got %b/%h exp 0/00000040", mem_fault, fault_pc); else pass_cnt++;
    drive(1'b1, STORE, 3'b001, 32'h101, 32'h0, 5'd0, 32'h44);
    next_cycle();
    idle();
    total_cnt++; if ({mem_req, mem_fault, fault_pc} !== {2'b01, 32'h44}) $display("FAIL sh_mis got %b/%h exp 01/00000044", {mem_req, mem_fault}, fault_pc); else pass_cnt++;
    next_cycle();
    drive(1'b1, LOAD, 3'b011, 32'h100, 32'h0, 5'd1, 32'h48);
    next_cycle();
    idle();
    total_cnt++; if ({mem_req, mem_fault, fault_pc} !== {2'b01, 32'h48}) $display("FAIL ld_illegal got %b/%h exp 01/00000048", {mem_req, mem_fault}, fault_pc); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_timeout();
    drive(1'b1, STORE, 3'b010, 32'h200, 32'h55, 5'd0, 32'h80);
    next_cycle();
    for (int i = 1; i <= 4; i++) begin
      total_cnt++; if (mem_req !== 1'b1) $display("FAIL to_req_c%0d got %b exp 1", i, mem_req); else pass_cnt++;
      total_cnt++; if (stall !== (i < 4)) $display("FAIL to_stall_c%0d got %b exp %b", i, stall, i < 4); else pass_cnt++;
      next_cycle();
    end
    idle();
    total_cnt++; if ({mem_req, mem_fault, wb_we} !== 3'b010) $display("FAIL to_end got %b exp 010", {mem_req, mem_fault, wb_we}); else pass_cnt++;
    total_cnt++; if (fault_pc !== 32'h80) $display("FAIL to_pc got %h exp 00000080", fault_pc); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1;
    next_cycle();
    total_cnt++; if ({mem_req, wb_we, mem_fault, stall} !== 4'b0) $display("FAIL ack_idle got %b exp 0000", {mem_req, wb_we, mem_fault, stall}); else pass_cnt++;
    idle();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, ADD, 3'b000, 32'h7, 32'h0, 5'd3, 32'h90);
    #1;
    total_cnt++; if (stall !== 1'b0) $display("FAIL add_stall got %b exp 0", stall); else pass_cnt++;
    next_cycle();
    total_cnt++; if ({wb_data, wb_rd, wb_we} !== {32'h7, 5'd3, 1'b1}) $display("FAIL add_wb got %h/%0d/%b exp 00000007/3/1", wb_data, wb_rd, wb_we); else pass_cnt++;
    drive(1'b1, LOAD, 3'b010, 32'h104, 32'h0, 5'd4, 32'h94);
    #1;
    total_cnt++; if (stall !== 1'b1) $display("FAIL lw_stall got %b exp 1", stall); else pass_cnt++;
    next_cycle();
    total_cnt++; if ({mem_req, mem_addr} !== {1'b1, 32'h104}) $display("FAIL lw_req got %b/%h exp 1/00000104", mem_req, mem_addr); else pass_cnt++;
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    next_cycle();
    drive(1'b1, BRANCH, 3'b000, 32'h9, 32'h0, 5'd6, 32'h98);
    mem_ack = 1'b0;
    total_cnt++; if ({wb_data, wb_rd, wb_we} !== {32'h11223344, 5'd4, 1'b1}) $display("FAIL lw_wb got %h/%0d/%b exp 11223344/4/1", wb_data, wb_rd, wb_we); else pass_cnt++;
    next_cycle();
    idle();
    total_cnt++; if ({wb_data, wb_we} !== {32'h9, 1'b0}) $display("FAIL branch_wb got %h/%b exp 00000009/0", wb_data, wb_we); else pass_cnt++;
    next_cycle();
  endtask

  task automatic test_reset_busy();
    drive(1'b1, LOAD, 3'b010, 32'h300, 32'h0, 5'd8, 32'hA0);
    next_cycle();
    total_cnt++; if ({mem_req, stall} !== 2'b11) $display("FAIL rb_busy got %b exp 11", {mem_req, stall}); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({mem_req, stall} !== 2'b00) $display("FAIL rb_drop got %b exp 00", {mem_req, stall}); else pass_cnt++;
    total_cnt++; if (fault_pc !== 32'h0) $display("FAIL rb_fault_pc got %h exp 0", fault_pc); else pass_cnt++;
    idle();
    #2 rst_n = 1'b1;
    next_cycle();
    total_cnt++; if ({mem_req, stall, mem_fault} !== 3'b000) $display("FAIL rb_after got %b exp 000", {mem_req, stall, mem_fault}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_lb();
    test_lhu();
    test_fault();
    test_timeout();
    test_ack_idle();
    test_back_to_back();
    test_reset_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
